// File: rtl/isqrt_arbiter.sv
// Two-client round-robin front end for one shared, in-order isqrt instance.
// Optional grant counters are enabled with `define ISQRT_ARBITER_STATS_EN.
module isqrt_arbiter #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_x_vld,
  input  logic [31:0] c0_x,
  output logic        c0_x_rdy,
  input  logic        c1_x_vld,
  input  logic [31:0] c1_x,
  output logic        c1_x_rdy,
  output logic        c0_y_vld,
  output logic [15:0] c0_y,
  output logic        c1_y_vld,
  output logic [15:0] c1_y,
  output logic        isqrt_x_vld,
  output logic [31:0] isqrt_x,
  input  logic        isqrt_y_vld,
  input  logic [15:0] isqrt_y,
  output logic        err
`ifdef ISQRT_ARBITER_STATS_EN
  ,
  output logic [15:0] c0_grant_cnt,
  output logic [15:0] c1_grant_cnt
`endif
);

  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           cnt;
  logic [MAX_INFLIGHT-1:0] tags;
  logic                    last_gnt;
  logic                    full;
  logic                    gnt0;
  logic                    gnt1;
  logic                    issue;
  logic                    pop;
  logic                    pop_tag;

  // Full is taken from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign full = (cnt == CW'(MAX_INFLIGHT));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!full) begin
      if (c0_x_vld && c1_x_vld) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = c0_x_vld;
        gnt1 = c1_x_vld;
      end
    end
  end

  assign c0_x_rdy    = gnt0;
  assign c1_x_rdy    = gnt1;
  assign isqrt_x_vld = (c0_x_vld && c0_x_rdy) || (c1_x_vld && c1_x_rdy);
  assign issue       = isqrt_x_vld;
  assign isqrt_x     = isqrt_x_vld ? (gnt1 ? c1_x : c0_x) : {32{1'bx}};

  // A result with nothing outstanding is flagged, not popped.
  assign pop     = isqrt_y_vld && (cnt != '0);
  assign pop_tag = tags[rd_ptr];

  always_ff @(posedge clk) begin
    if (issue) tags[wr_ptr] <= gnt1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      last_gnt <= 1'b1;
      err      <= 1'b0;
      c0_y_vld <= 1'b0;
      c1_y_vld <= 1'b0;
      c0_y     <= '0;
      c1_y     <= '0;
    end else begin
      if (issue) begin
        wr_ptr   <= wr_ptr + PW'(1);
        last_gnt <= gnt1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({issue, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (isqrt_y_vld && (cnt == '0)) err <= 1'b1;
      c0_y_vld <= pop && !pop_tag;
      c1_y_vld <= pop && pop_tag;
      if (pop && !pop_tag) c0_y <= isqrt_y;
      if (pop && pop_tag)  c1_y <= isqrt_y;
    end
  end

`ifdef ISQRT_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_grant_cnt <= '0;
      c1_grant_cnt <= '0;
    end else begin
      if (issue && gnt0) c0_grant_cnt <= c0_grant_cnt + 16'd1;
      if (issue && gnt1) c1_grant_cnt <= c1_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed bench for isqrt_arbiter; includes a fixed-latency isqrt stand-in
// whose results can be stalled, plus a spurious-result injector.
module tb_isqrt_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_x_vld, c1_x_vld;
  logic [31:0] c0_x, c1_x;
  logic        c0_x_rdy, c1_x_rdy;
  logic        c0_y_vld, c1_y_vld;
  logic [15:0] c0_y, c1_y;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;
  logic        err;
`ifdef ISQRT_ARBITER_STATS_EN
  logic [15:0] c0_grant_cnt, c1_grant_cnt;
`endif

  logic        stall = 1'b0;
  logic        spur = 1'b0;
  logic        m_vld = 1'b0;
  logic [15:0] m_y = '0;
  int unsigned cyc = 0;
  int          ncmp = 0;
  int          nfail = 0;

  typedef struct packed {
    int unsigned due;
    logic [31:0] x;
  } req_t;
  req_t q[$];

  isqrt_arbiter #(.MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst),
    .c0_x_vld(c0_x_vld), .c0_x(c0_x), .c0_x_rdy(c0_x_rdy),
    .c1_x_vld(c1_x_vld), .c1_x(c1_x), .c1_x_rdy(c1_x_rdy),
    .c0_y_vld(c0_y_vld), .c0_y(c0_y), .c1_y_vld(c1_y_vld), .c1_y(c1_y),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .err(err)
`ifdef ISQRT_ARBITER_STATS_EN
    , .c0_grant_cnt(c0_grant_cnt), .c1_grant_cnt(c1_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt_f(input logic [31:0] v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(v)) r++;
    return 16'(r);
  endfunction

  assign isqrt_y_vld = m_vld | spur;
  assign isqrt_y     = spur ? 16'd0 : m_y;

  always @(posedge clk) begin
    if (rst) q.delete();
    else if (isqrt_x_vld) q.push_back('{due: cyc + LAT, x: isqrt_x});
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    m_vld <= 1'b0;
    if (!rst && !stall && q.size() > 0 && q[0].due <= cyc) begin
      m_vld <= 1'b1;
      m_y   <= isqrt_f(q[0].x);
      void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; c0_x_vld = 1'b0; c1_x_vld = 1'b0; c0_x = '0; c1_x = '0;
    repeat (2) tick();
    #1;
    chk1("rst_c0_y_vld", c0_y_vld, 1'b0);
    chk1("rst_c1_y_vld", c1_y_vld, 1'b0);
    chk32("rst_c0_y", 32'(c0_y), 32'd0);
    chk32("rst_c1_y", 32'(c1_y), 32'd0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // Single client: 144 -> 12, visible LAT+1 cycles after issue
    c0_x_vld = 1'b1; c0_x = 32'd144; #1;
    chk1("single_c0_rdy", c0_x_rdy, 1'b1);
    chk1("single_c1_rdy", c1_x_rdy, 1'b0);
    chk1("single_isqrt_vld", isqrt_x_vld, 1'b1);
    chk32("single_isqrt_x", isqrt_x, 32'd144);
    tick(); c0_x_vld = 1'b0; #1;
    chk1("single_y_early1", c0_y_vld, 1'b0);
    chk1("single_no_issue", isqrt_x_vld, 1'b0);
    tick(); #1;
    chk1("single_y_early2", c0_y_vld, 1'b0);
    tick(); #1;
    chk1("single_c0_y_vld", c0_y_vld, 1'b1);
    chk32("single_c0_y", 32'(c0_y), 32'd12);
    chk1("single_c1_y_vld", c1_y_vld, 1'b0);
    tick(); #1;
    chk1("single_y_pulse", c0_y_vld, 1'b0);
    chk32("single_y_hold", 32'(c0_y), 32'd12);

    // Contention from reset: c0 first, then alternate
    rst = 1'b1; tick(); rst = 1'b0;
    c0_x_vld = 1'b1; c1_x_vld = 1'b1; c0_x = 32'd16; c1_x = 32'd81; #1;
    chk1("cont_g1_c0", c0_x_rdy, 1'b1);
    chk1("cont_g1_c1", c1_x_rdy, 1'b0);
    chk32("cont_g1_x", isqrt_x, 32'd16);
    tick(); #1;
    chk1("cont_g2_c0", c0_x_rdy, 1'b0);
    chk1("cont_g2_c1", c1_x_rdy, 1'b1);
    chk32("cont_g2_x", isqrt_x, 32'd81);
    tick(); #1;
    chk1("cont_g3_c0", c0_x_rdy, 1'b1);
    chk32("cont_g3_x", isqrt_x, 32'd16);
    tick(); #1;
    chk1("cont_g4_c1", c1_x_rdy, 1'b1);
    chk1("cont_r1_vld", c0_y_vld, 1'b1);
    chk32("cont_r1_y", 32'(c0_y), 32'd4);
    chk1("cont_r1_other", c1_y_vld, 1'b0);
    c0_x_vld = 1'b0; c1_x_vld = 1'b0;
    tick(); #1;
    chk1("cont_r2_vld", c1_y_vld, 1'b1);
    chk32("cont_r2_y", 32'(c1_y), 32'd9);
    chk1("cont_r2_other", c0_y_vld, 1'b0);
    tick(); #1;
    chk1("cont_r3_vld", c0_y_vld, 1'b1);
    chk32("cont_r3_y", 32'(c0_y), 32'd4);
    chk1("cont_r3_other", c1_y_vld, 1'b0);
    tick(); #1;
    chk1("cont_idle_c0", c0_y_vld, 1'b0);
    chk1("cont_idle_c1", c1_y_vld, 1'b0);

    // Full: results stalled, exactly four issues then backpressure
    tick();
    stall = 1'b1; c0_x_vld = 1'b1; c0_x = 32'd25;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("full_rdy_open", c0_x_rdy, 1'b1);
      tick();
    end
    #1;
    chk1("full_rdy_closed1", c0_x_rdy, 1'b0);
    chk1("full_no_issue", isqrt_x_vld, 1'b0);
    tick(); #1;
    chk1("full_rdy_closed2", c0_x_rdy, 1'b0);
    stall = 1'b0;
    @(negedge clk); #1;
    chk1("full_pop_present", isqrt_y_vld, 1'b1);
    chk1("full_no_passthru", c0_x_rdy, 1'b0);
    tick(); #1;
    chk1("full_rdy_back", c0_x_rdy, 1'b1);
    chk1("full_first_y_vld", c0_y_vld, 1'b1);
    chk32("full_first_y", 32'(c0_y), 32'd5);
    c0_x_vld = 1'b0;
    repeat (6) tick();

    // Spurious result with nothing in flight
    #1;
    chk1("spur_err_before", err, 1'b0);
    spur = 1'b1; tick(); spur = 1'b0; #1;
    chk1("spur_err_set", err, 1'b1);
    chk1("spur_c0_y_vld", c0_y_vld, 1'b0);
    chk1("spur_c1_y_vld", c1_y_vld, 1'b0);
    tick(); #1;
    chk1("spur_err_sticky", err, 1'b1);
    chk1("spur_c0_y_vld2", c0_y_vld, 1'b0);

    // Reset with three requests in flight (last grant = c0)
    stall = 1'b1; c1_x_vld = 1'b1; c1_x = 32'd49;
    tick(); tick();
    c1_x_vld = 1'b0; c0_x_vld = 1'b1; c0_x = 32'd36;
    tick(); c0_x_vld = 1'b0;
    rst = 1'b1; #1;
    chk1("mid_rst_err", err, 1'b0);
    chk1("mid_rst_c0_y_vld", c0_y_vld, 1'b0);
    chk1("mid_rst_c1_y_vld", c1_y_vld, 1'b0);
    tick(); rst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk1("mid_no_stale_c0", c0_y_vld, 1'b0);
      chk1("mid_no_stale_c1", c1_y_vld, 1'b0);
    end
    chk1("mid_err_clear", err, 1'b0);
    spur = 1'b1; tick(); spur = 1'b0; #1;
    chk1("mid_count_zero", err, 1'b1);
    c0_x_vld = 1'b1; c1_x_vld = 1'b1; c0_x = 32'd4; c1_x = 32'd9; #1;
    chk1("mid_cont_c0", c0_x_rdy, 1'b1);
    chk1("mid_cont_c1", c1_x_rdy, 1'b0);
    tick(); c0_x_vld = 1'b0; c1_x_vld = 1'b0;
    repeat (5) tick();

`ifdef ISQRT_ARBITER_STATS_EN
    // Grant counter wrap: 0x10001 c1 issues
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk32("stats_rst_c1", 32'(c1_grant_cnt), 32'd0);
    c1_x_vld = 1'b1; c1_x = 32'd1;
    for (int i = 0; i < 32'h10001; i++) tick();
    c1_x_vld = 1'b0; #1;
    chk32("stats_c1_wrap", 32'(c1_grant_cnt), 32'd1);
    chk32("stats_c0_zero", 32'(c0_grant_cnt), 32'd0);
    repeat (5) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
